// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between the I2C slave (port A) and a local host (port B).
// A writes are captured into a one-deep buffer and always win; A reads and B requests round-robin.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              i_ck,
  input  logic              i_rst,
  input  logic              a_cs_n,
  input  logic              a_rw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ovf,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rr_q, rr_d;           // 1: B has the next round-robin turn
  logic                own_b_q, own_b_d;
  logic                rd_q, rd_d;
  logic                cs_n_q, cs_n_d;
  logic                we_n_q, we_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
  logic                b_gnt_q, b_gnt_d;
  logic                b_rvalid_q, b_rvalid_d;
  logic                ovf_q, ovf_d;
  logic                buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
  logic                a_cs_n_q, a_rw_q;

  logic                a_wr_evt_s;
  logic                a_rd_req_s;
  logic                win_b_s;
  logic                drain_s;

  // A write strobe fires only on entry into the write condition, so a held strobe is captured once.
  assign a_wr_evt_s = !a_cs_n && !a_rw && (a_cs_n_q || a_rw_q);
  assign a_rd_req_s = !a_cs_n && a_rw;
  assign win_b_s    = b_req && (!a_rd_req_s || rr_q);

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    own_b_d    = own_b_q;
    rd_d       = rd_q;
    cs_n_d     = 1'b1;
    we_n_d     = 1'b1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    b_gnt_d    = 1'b0;
    b_rvalid_d = 1'b0;
    drain_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_vld_q) begin
          drain_s = 1'b1;
          cs_n_d  = 1'b0;
          we_n_d  = 1'b0;
          addr_d  = buf_addr_q;
          wdata_d = buf_data_q;
          own_b_d = 1'b0;
          rd_d    = 1'b0;
          state_d = ST_ACC;
        end else if (a_rd_req_s || b_req) begin
          rr_d    = !win_b_s;
          cs_n_d  = 1'b0;
          own_b_d = win_b_s;
          b_gnt_d = win_b_s;
          state_d = ST_ACC;
          if (win_b_s) begin
            we_n_d  = !b_we;
            addr_d  = b_addr;
            wdata_d = b_wdata;
            rd_d    = !b_we;
          end else begin
            we_n_d  = 1'b1;
            addr_d  = a_addr;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (rd_q) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        state_d = ST_IDLE;
        if (own_b_q) begin
          b_rdata_d  = mem_rdata;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = mem_rdata;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A write buffer: a capture while full and not draining overwrites and flags overflow.
  always_comb begin
    buf_vld_d  = buf_vld_q && !drain_s;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    ovf_d      = ovf_q;
    if (a_wr_evt_s) begin
      buf_vld_d  = 1'b1;
      buf_addr_d = a_addr;
      buf_data_d = a_wdata;
      if (buf_vld_q && !drain_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      buf_addr_d = buf_addr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      own_b_q    <= 1'b0;
      rd_q       <= 1'b0;
      cs_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      a_rdata_q  <= {DATA_W{1'b0}};
      b_rdata_q  <= {DATA_W{1'b0}};
      b_gnt_q    <= 1'b0;
      b_rvalid_q <= 1'b0;
      ovf_q      <= 1'b0;
      buf_vld_q  <= 1'b0;
      buf_addr_q <= {ADDR_W{1'b0}};
      buf_data_q <= {DATA_W{1'b0}};
      a_cs_n_q   <= 1'b1;
      a_rw_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      own_b_q    <= own_b_d;
      rd_q       <= rd_d;
      cs_n_q     <= cs_n_d;
      we_n_q     <= we_n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      b_gnt_q    <= b_gnt_d;
      b_rvalid_q <= b_rvalid_d;
      ovf_q      <= ovf_d;
      buf_vld_q  <= buf_vld_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      a_cs_n_q   <= a_cs_n;
      a_rw_q     <= a_rw;
    end
  end

  assign a_rdata   = a_rdata_q;
  assign a_ovf     = ovf_q;
  assign b_gnt     = b_gnt_q;
  assign b_rdata   = b_rdata_q;
  assign b_rvalid  = b_rvalid_q;
  assign mem_cs_n  = cs_n_q;
  assign mem_we_n  = we_n_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transactional reference memory plus a read-data scoreboard for port B.
module tb_sram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          a_cs_n, a_rw;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          a_ovf;
  logic          b_req, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic          b_gnt, b_rvalid;
  logic          mem_cs_n, mem_we_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_ck(clk), .i_rst(i_rst),
    .a_cs_n(a_cs_n), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ovf(a_ovf),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_cs_n(mem_cs_n), .mem_we_n(mem_we_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM macro model: clears on reset, registered read data.
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) sram[i] <= '0;
    end else if (!mem_cs_n) begin
      if (!mem_we_n) sram[mem_addr] <= mem_wdata;
      else           mem_rdata <= sram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] ref_mem [16];

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every b_rvalid must match the oldest expected read, two cycles after its grant.
  always @(negedge clk) begin
    if (b_rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_b_rvalid", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("b_rdata", b_rdata, mon_e.data);
        chk("b_rvalid_latency", cyc, mon_e.due);
      end
    end
  end

  task automatic note_gnt(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_t e;
    if (we) begin
      ref_mem[addr] = data;
    end else begin
      e.data = ref_mem[addr];
      e.due  = cyc + 2;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_gnt(output int n, output bit got);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (b_gnt === 1'b1) got = 1'b1;
    end
    if (!got) chk("b_gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic b_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input bit chk_lat);
    int n;
    bit got;
    @(negedge clk);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
    wait_gnt(n, got);
    b_req = 1'b0;
    if (got) begin
      note_gnt(we, addr, data);
      if (chk_lat) chk("b_gnt_latency", n, 32'd1);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic a_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int hold);
    @(negedge clk);
    a_cs_n = 1'b0; a_rw = 1'b0; a_addr = addr; a_wdata = data;
    ref_mem[addr] = data;
    repeat (hold) @(negedge clk);
    a_cs_n = 1'b1; a_rw = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic a_read(input logic [AW-1:0] addr);
    @(negedge clk);
    a_cs_n = 1'b0; a_rw = 1'b1; a_addr = addr;
    repeat (6) @(negedge clk);
    chk("a_rdata", a_rdata, ref_mem[addr]);
    a_cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  got;
    int  prev_owner;
    int  nacc;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;

    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    i_rst = 1'b1; a_cs_n = 1'b1; a_rw = 1'b1; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    chk("rst_mem_cs_n", mem_cs_n, 32'd1);
    chk("rst_mem_we_n", mem_we_n, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_b_rdata", b_rdata, 32'd0);
    chk("rst_b_gnt", b_gnt, 32'd0);
    chk("rst_b_rvalid", b_rvalid, 32'd0);
    chk("rst_a_ovf", a_ovf, 32'd0);

    // Reset in the middle of an access cycle.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
    @(negedge clk);
    chk("midacc_gnt", b_gnt, 32'd1);
    chk("midacc_cs_n", mem_cs_n, 32'd0);
    b_req = 1'b0; i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("midrst_cs_n", mem_cs_n, 32'd1);
    chk("midrst_gnt", b_gnt, 32'd0);
    chk("midrst_rvalid", b_rvalid, 32'd0);
    chk("midrst_ovf", a_ovf, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_rvalid", b_rvalid, 32'd0);
    end

    // B write then read back.
    b_access(1'b1, 4'd3, 8'h5A, 1'b1);
    b_access(1'b0, 4'd3, 8'h00, 1'b1);

    // A write lands during a B read and is served ahead of the next B request.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
    wait_gnt(n, got);
    if (got) note_gnt(1'b0, 4'd7, 8'h00);
    @(negedge clk);
    a_cs_n = 1'b0; a_rw = 1'b0; a_addr = 4'd7; a_wdata = 8'hC3;
    ref_mem[7] = 8'hC3;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      a_cs_n = 1'b1; a_rw = 1'b1;
      if (b_gnt === 1'b1) got = 1'b1;
    end
    b_req = 1'b0;
    chk("a_write_before_b", n, 32'd4);
    if (got) note_gnt(1'b0, 4'd7, 8'h00);
    repeat (3) @(negedge clk);

    // Contention: A read of addr 2 against continuous B reads of addr 9.
    b_access(1'b1, 4'd2, 8'h6E, 1'b1);
    b_access(1'b1, 4'd9, 8'h9D, 1'b1);
    @(negedge clk);
    a_cs_n = 1'b0; a_rw = 1'b1; a_addr = 4'd2;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd9;
    prev_owner = -1; nacc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_cs_n === 1'b0) begin
        if (prev_owner >= 0) chk("rr_alternate", b_gnt, (prev_owner == 1) ? 32'd0 : 32'd1);
        prev_owner = (b_gnt === 1'b1) ? 1 : 0;
        nacc++;
        if (b_gnt === 1'b1) note_gnt(1'b0, 4'd9, 8'h00);
      end
    end
    a_cs_n = 1'b1; b_req = 1'b0;
    chk("rr_access_count", nacc, 32'd10);
    repeat (3) @(negedge clk);
    chk("rr_a_rdata", a_rdata, 32'h6E);

    // Randomized serial traffic.
    for (int k = 0; k < 40; k++) begin
      ra = 4'($urandom_range(0, 15));
      rd = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: b_access(1'b1, ra, rd, 1'b1);
        1: b_access(1'b0, ra, 8'h00, 1'b1);
        2: a_write(ra, rd, $urandom_range(1, 3));
        default: a_read(ra);
      endcase
    end
    chk("random_no_ovf", a_ovf, 32'd0);

    // Second A write captured in the same cycle the buffer drains: no overflow.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd0;
    wait_gnt(n, got);
    if (got) note_gnt(1'b0, 4'd0, 8'h00);
    b_req = 1'b0;
    a_cs_n = 1'b0; a_rw = 1'b0; a_addr = 4'd10; a_wdata = 8'h33; ref_mem[10] = 8'h33;
    @(negedge clk);
    a_cs_n = 1'b1;
    @(negedge clk);
    a_cs_n = 1'b0; a_addr = 4'd11; a_wdata = 8'h44; ref_mem[11] = 8'h44;
    @(negedge clk);
    a_cs_n = 1'b1; a_rw = 1'b1;
    repeat (4) @(negedge clk);
    chk("drain_same_cycle_no_ovf", a_ovf, 32'd0);

    // Overflow: two A writes captured while B owns the SRAM.
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd1;
    a_cs_n = 1'b0; a_rw = 1'b0; a_addr = 4'd4; a_wdata = 8'h22;
    @(negedge clk);
    chk("ovf_b_wins", b_gnt, 32'd1);
    if (b_gnt === 1'b1) note_gnt(1'b0, 4'd1, 8'h00);
    b_req = 1'b0; a_cs_n = 1'b1;
    @(negedge clk);
    a_cs_n = 1'b0; a_addr = 4'd5; a_wdata = 8'h11; ref_mem[5] = 8'h11;
    @(negedge clk);
    a_cs_n = 1'b1; a_rw = 1'b1;
    chk("ovf_set", a_ovf, 32'd1);
    repeat (4) @(negedge clk);
    b_access(1'b0, 4'd5, 8'h00, 1'b1);
    b_access(1'b0, 4'd4, 8'h00, 1'b1);
    chk("ovf_sticky", a_ovf, 32'd1);

    // Idle: nothing requested for 20 cycles.
    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", {mem_cs_n, b_gnt, b_rvalid}, 32'd4);
    end
    chk("ovf_still_sticky", a_ovf, 32'd1);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    for (int i = 0; i < 16; i++) chk("sram_contents", sram[i], ref_mem[i]);

    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    chk("ovf_cleared_by_reset", a_ovf, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
